// File: rtl/bus_arbiter_if.sv
// Command/response bus used by both masters and by the shared slave port.
// "master" is the side that issues commands; "slave" is the side that accepts them.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            read;
  logic            write;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] dataena;
  logic            waitrequest;
  logic            valid;
  logic [DW-1:0]   rdata;

  modport master (
    output read, write, addr, wdata, dataena,
    input  waitrequest, valid, rdata
  );

  modport slave (
    input  read, write, addr, wdata, dataena,
    output waitrequest, valid, rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter with a single outstanding
// transaction. Reads that get no response within TIMEOUT cycles complete
// with a poison value and raise a sticky error flag.
module bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  bus_arbiter_if.slave     m0,
  bus_arbiter_if.slave     m1,
  bus_arbiter_if.master    s,
  output logic             s_burstcount,
  output logic [1:0]       grant,
  output logic             timeout_err
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t          state, state_n;
  logic            last_grant;   // index of the master that completed most recently
  logic            op_read;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] dataena_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      valid_q;
  logic [CW-1:0]   cnt;

  logic req0, req1, winner;
  logic accept, resp_ok, resp_to, done;

  // Request decode and round-robin pick: on a tie the master that did not go last wins.
  always_comb begin
    req0   = m0.read | m0.write;
    req1   = m1.read | m1.write;
    winner = (req0 && req1) ? ~last_grant : req1;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous,
    // so it lives inside the clocked block rather than in the sensitivity list.
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_n = state;
    accept  = 1'b0;
    resp_ok = 1'b0;
    resp_to = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept  = 1'b1;
          state_n = CMD;
        end
      end
      CMD: begin
        if (!s.waitrequest) begin
          state_n = op_read ? RESP : IDLE;
          done    = !op_read;
        end
      end
      RESP: begin
        if (s.valid) begin
          resp_ok = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          resp_to = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Master handshake: only the winner in an IDLE cycle sees waitrequest drop.
  assign m0.waitrequest = !(rst && accept && !winner);
  assign m1.waitrequest = !(rst && accept &&  winner);
  assign m0.valid       = valid_q[0];
  assign m1.valid       = valid_q[1];
  assign m0.rdata       = rdata_q;
  assign m1.rdata       = rdata_q;

  // Slave command is presented only while in CMD, from the latched fields.
  assign s.read       = (state == CMD) &&  op_read;
  assign s.write      = (state == CMD) && !op_read;
  assign s.addr       = addr_q;
  assign s.wdata      = wdata_q;
  assign s.dataena    = dataena_q;
  assign s_burstcount = 1'b1;

  // Control state: ownership, fairness pointer, response pulse, wait counter, error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant       <= 2'b00;
      last_grant  <= 1'b1;
      op_read     <= 1'b0;
      valid_q     <= 2'b00;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      valid_q <= 2'b00;
      if (accept) begin
        grant   <= winner ? 2'b10 : 2'b01;
        op_read <= winner ? m1.read : m0.read;   // read wins when both strobes are high
        cnt     <= '0;
      end
      if (state == RESP && !done) cnt <= cnt + 1'b1;
      if (resp_ok || resp_to)    valid_q <= grant;
      if (resp_to)               timeout_err <= 1'b1;
      if (done) begin
        grant      <= 2'b00;
        last_grant <= grant[1];
      end
    end
  end

  // Command and read-data holding registers.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are not reset; they are always qualified
    // by control state that is, so their power-up contents are never observed.
    if (accept) begin
      addr_q    <= winner ? m1.addr    : m0.addr;
      wdata_q   <= winner ? m1.wdata   : m0.wdata;
      dataena_q <= winner ? m1.dataena : m0.dataena;
    end
    if (resp_ok)      rdata_q <= s.rdata;
    else if (resp_to) rdata_q <= DW'(32'hDEADBEEF);
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width; TIMEOUT, default 255, maximum RESP-state wait in cycles before abort.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 mX_read, mX_write  input  1 each  master X (X=0,1) command strobes, held until accepted.
REQ-005 mX_addr  input  AW; mX_wdata  input  DW; mX_dataena  input  DW/8  master X command fields.
REQ-006 mX_waitrequest  output  1  master X command not accepted this cycle.
REQ-007 mX_valid  output  1  master X read data valid, one-cycle pulse.
REQ-008 mX_rdata  output  DW  master X read data.
REQ-009 s_read, s_write  output  1 each  slave-side command strobes to bus.
REQ-010 s_addr  output  AW; s_wdata  output  DW; s_dataena  output  DW/8; s_burstcount  output  1  (constant 1).
REQ-011 s_waitrequest  input  1; s_valid  input  1; s_rdata  input  DW  slave-side handshake and read data.
REQ-012 grant  output  2  one-hot owner of the slave bus (bit X = master X); 0 when idle.
REQ-013 timeout_err  output  1  sticky flag, read response timed out.

Function
REQ-014 FSM states SHALL be IDLE, CMD, RESP.
REQ-015 Request of master X SHALL be mX_read|mX_write.
REQ-016 IDLE: single request wins; both requesting -> master not in last_grant wins (round-robin).
REQ-017 IDLE with a winner: winner's mX_waitrequest low that cycle; addr/wdata/dataena/op latched; grant set; next CMD.
REQ-018 mX_waitrequest SHALL be high in every cycle other than the acceptance cycle of REQ-017.
REQ-019 mX_read and mX_write both high SHALL be treated as read; write dropped.
REQ-020 CMD: s_read or s_write high from latched op, s_addr/s_wdata/s_dataena from latched fields, held until s_waitrequest low.
REQ-021 CMD with s_waitrequest low: write -> IDLE, grant cleared, last_grant updated; read -> RESP.
REQ-022 RESP: s_read/s_write low; 8-bit-min counter increments per cycle.
REQ-023 RESP with s_valid high: s_rdata registered; mX_valid pulses for the granted master the next cycle with that data; FSM -> IDLE; last_grant updated.
REQ-024 Read latency SHALL be: acceptance cycle N, s_read at N+1 (zero slave wait), mX_valid one cycle after s_valid.
REQ-025 RESP counter reaching TIMEOUT without s_valid: mX_valid pulses with rdata 32'hDEADBEEF, timeout_err set, FSM -> IDLE.
REQ-026 s_valid in IDLE or CMD SHALL be ignored; no mX_valid generated.
REQ-027 Non-granted master's mX_valid SHALL stay low; mX_rdata may hold stale data.
REQ-028 A master re-requesting in the cycle after completion SHALL be arbitrated normally in IDLE, with no extra bubble.
REQ-029 Only one outstanding transaction SHALL exist; no pipelining.

Reset
REQ-030 rst low at a clk edge: FSM->IDLE, grant=0, s_read=s_write=0, mX_valid=0, mX_waitrequest=1, timeout_err=0, counter=0, last_grant=master 1 (master 0 wins first tie).
REQ-031 Reset mid-CMD or mid-RESP SHALL abort silently; no mX_valid pulse for the aborted transaction.

Verification
REQ-032 m0 read addr 0x0000_0100, slave valid 2 cycles after s_read with 0x1234_5678 -> m0_valid one pulse, m0_rdata=0x1234_5678, grant=01 throughout.
REQ-033 m0 and m1 write simultaneously after reset -> m0 served first, then m1; s_write twice, addresses in that order; next tie -> m0 first again.
REQ-034 s_waitrequest high 3 cycles during m1 write 0xCAFE_F00D, dataena 4'b0011 -> s_write held 4 cycles, fields stable, m1_waitrequest stays high.
REQ-035 m0 read, slave never responds -> after TIMEOUT cycles m0_valid with 0xDEADBEEF, timeout_err=1 until reset.
REQ-036 rst low during RESP, then late s_valid -> no mX_valid, grant=0, FSM IDLE.
